// File: rtl/sat_fade_if.sv
// Pixel/control bundle for the saturation fader: the frame controls, pixel stream and sideband.
// The master drives the stream and the controls; the slave (the fader) returns the processed pixels.
interface sat_fade_if #(
  parameter int HUE_W  = 9,
  parameter int SAT_W  = 7,
  parameter int VAL_W  = 8,
  parameter int PASS_W = 24,
  parameter int GAIN_W = 8
);
  localparam int PW = HUE_W + SAT_W + VAL_W;

  logic              en;
  logic [1:0]        mode;
  logic [GAIN_W-1:0] gain;
  logic              frame_start;
  logic [PW-1:0]     pixel_in;
  logic [PW-1:0]     pixel_out;
  logic [PASS_W-1:0] pass_in;
  logic [PASS_W-1:0] pass_thru;
  logic              fading;

  modport master (
    output en, mode, gain, frame_start, pixel_in, pass_in,
    input  pixel_out, pass_thru, fading
  );

  modport slave (
    input  en, mode, gain, frame_start, pixel_in, pass_in,
    output pixel_out, pass_thru, fading
  );
endinterface

// File: rtl/sat_fade.sv
// Saturation fader: scales the saturation field by a gain that ramps toward a per-frame target
// in STEP increments, through a fixed two-stage pipeline; hue, value and sideband pass untouched.
module sat_fade #(
  parameter int HUE_W  = 9,
  parameter int SAT_W  = 7,
  parameter int VAL_W  = 8,
  parameter int PASS_W = 24,
  parameter int GAIN_W = 8,
  parameter int STEP   = 16
) (
  input  logic      clk,
  input  logic      rst,
  sat_fade_if.slave bus
);
  localparam int PW     = HUE_W + SAT_W + VAL_W;
  localparam int PROD_W = SAT_W + GAIN_W;

  localparam logic [GAIN_W-1:0] UNITY   = GAIN_W'(1 << (GAIN_W - 1));
  localparam logic [GAIN_W:0]   STEP_X  = (GAIN_W + 1)'(STEP);
  localparam logic [GAIN_W-1:0] STEP_G  = GAIN_W'(STEP);
  localparam logic [PROD_W-1:0] SAT_MAX = PROD_W'((1 << SAT_W) - 1);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  state_t            state_q, state_d;
  logic [GAIN_W-1:0] g_q, g_d;
  logic              en_s_q, en_s_d;
  logic [1:0]        mode_s_q, mode_s_d;
  logic [GAIN_W-1:0] gain_s_q, gain_s_d;
  logic              fading_q, fading_d;
  logic [GAIN_W-1:0] target;

  logic [HUE_W-1:0]  hue1_q, hue1_d;
  logic [VAL_W-1:0]  val1_q, val1_d;
  logic [PASS_W-1:0] pass1_q, pass1_d;
  logic [PROD_W-1:0] prod1_q, prod1_d;
  logic [PW-1:0]     pixel_out_q, pixel_out_d;
  logic [PASS_W-1:0] pass_thru_q, pass_thru_d;

  logic [SAT_W-1:0]  sat_in;
  logic [PROD_W-1:0] shifted;
  logic [SAT_W-1:0]  sat_new;

  function automatic logic [GAIN_W-1:0] target_of(input logic e, input logic [1:0] m,
                                                  input logic [GAIN_W-1:0] g);
    if (e) return '0;
    case (m)
      2'b01:   return '0;
      2'b10:   return g;
      default: return UNITY;
    endcase
  endfunction

  // Gain control: shadows, target and the ramp all move only on frame_start.
  always_comb begin
    en_s_d   = en_s_q;
    mode_s_d = mode_s_q;
    gain_s_d = gain_s_q;
    g_d      = g_q;
    state_d  = state_q;
    fading_d = fading_q;
    target   = target_of(en_s_q, mode_s_q, gain_s_q);
    if (bus.frame_start) begin
      en_s_d   = bus.en;
      mode_s_d = bus.mode;
      gain_s_d = bus.gain;
      target   = target_of(bus.en, bus.mode, bus.gain);
      // Extra headroom bit keeps the step comparisons free of wrap at either end.
      if (g_q < target) begin
        g_d = ({1'b0, g_q} + STEP_X >= {1'b0, target}) ? target : g_q + STEP_G;
      end else if (g_q > target) begin
        g_d = ({1'b0, g_q} >= {1'b0, target} + STEP_X) ? g_q - STEP_G : target;
      end
      if (g_d < target)      state_d = UP;
      else if (g_d > target) state_d = DOWN;
      else                   state_d = IDLE;
      fading_d = (state_d != IDLE);
    end
  end

  // Datapath: stage 1 multiplies by the current gain, stage 2 rescales and saturates.
  always_comb begin
    sat_in      = bus.pixel_in[VAL_W +: SAT_W];
    hue1_d      = bus.pixel_in[PW-1 -: HUE_W];
    val1_d      = bus.pixel_in[VAL_W-1:0];
    pass1_d     = bus.pass_in;
    prod1_d     = PROD_W'(sat_in) * PROD_W'(g_q);
    shifted     = prod1_q >> (GAIN_W - 1);
    sat_new     = (shifted > SAT_MAX) ? {SAT_W{1'b1}} : shifted[SAT_W-1:0];
    pixel_out_d = {hue1_q, sat_new, val1_q};
    pass_thru_d = pass1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      g_q         <= UNITY;
      en_s_q      <= 1'b0;
      mode_s_q    <= 2'b00;
      gain_s_q    <= UNITY;
      fading_q    <= 1'b0;
      hue1_q      <= '0;
      val1_q      <= '0;
      pass1_q     <= '0;
      prod1_q     <= '0;
      pixel_out_q <= '0;
      pass_thru_q <= '0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      en_s_q      <= en_s_d;
      mode_s_q    <= mode_s_d;
      gain_s_q    <= gain_s_d;
      fading_q    <= fading_d;
      hue1_q      <= hue1_d;
      val1_q      <= val1_d;
      pass1_q     <= pass1_d;
      prod1_q     <= prod1_d;
      pixel_out_q <= pixel_out_d;
      pass_thru_q <= pass_thru_d;
    end
  end

  assign bus.pixel_out = pixel_out_q;
  assign bus.pass_thru = pass_thru_q;
  assign bus.fading    = fading_q;
endmodule

// File: tb/tb_sat_fade.sv
// Directed-plus-random bench for sat_fade against a frame-level gain model and a 2-cycle latency model.
module tb_sat_fade;
  localparam int HUE_W = 9, SAT_W = 7, VAL_W = 8, PASS_W = 24, GAIN_W = 8;
  localparam int PW = HUE_W + SAT_W + VAL_W;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  sat_fade_if #(.HUE_W(HUE_W), .SAT_W(SAT_W), .VAL_W(VAL_W), .PASS_W(PASS_W), .GAIN_W(GAIN_W)) bus ();

  sat_fade #(.HUE_W(HUE_W), .SAT_W(SAT_W), .VAL_W(VAL_W), .PASS_W(PASS_W),
             .GAIN_W(GAIN_W), .STEP(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Reference state: gain as an integer, fading flag, and the last two predicted outputs.
  int            m_g = 128;
  bit            m_fading = 1'b0;
  logic [PW-1:0]     exp_pix [2];
  logic [PASS_W-1:0] exp_pass[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int target_of(input bit e, input int m, input int g);
    if (e) return 0;
    if (m == 1) return 0;
    if (m == 2) return g;
    return 128;
  endfunction

  // One clock: predict from pre-edge inputs, advance, then compare just after the edge.
  task automatic tick();
    int sat, scaled, t;
    logic [PW-1:0] newpix;
    sat    = int'(bus.pixel_in[VAL_W +: SAT_W]);
    scaled = (sat * m_g) / 128;
    if (scaled > 127) scaled = 127;
    newpix = bus.pixel_in;
    newpix[VAL_W +: SAT_W] = SAT_W'(scaled);
    if (rst) begin
      exp_pix[0] = '0;  exp_pix[1] = '0;
      exp_pass[0] = '0; exp_pass[1] = '0;
      m_g = 128;
      m_fading = 1'b0;
    end else begin
      exp_pix[1]  = exp_pix[0];  exp_pix[0]  = newpix;
      exp_pass[1] = exp_pass[0]; exp_pass[0] = bus.pass_in;
      if (bus.frame_start) begin
        t = target_of(bus.en, int'(bus.mode), int'(bus.gain));
        if (m_g < t)      m_g = (m_g + 16 > t) ? t : m_g + 16;
        else if (m_g > t) m_g = (m_g - 16 < t) ? t : m_g - 16;
        m_fading = (m_g != t);
      end
    end
    @(posedge clk);
    #1;
    check("pixel_out", 32'(bus.pixel_out), 32'(exp_pix[1]));
    check("pass_thru", 32'(bus.pass_thru), 32'(exp_pass[1]));
    check("fading", 32'(bus.fading), 32'(m_fading));
  endtask

  task automatic rand_pixel();
    bus.pixel_in = PW'($urandom);
    bus.pass_in  = PASS_W'($urandom);
  endtask

  task automatic set_sat(input int sat);
    rand_pixel();
    bus.pixel_in[VAL_W +: SAT_W] = SAT_W'(sat);
  endtask

  task automatic frame(input int extra);
    bus.frame_start = 1'b1;
    rand_pixel();
    tick();
    bus.frame_start = 1'b0;
    for (int i = 0; i < extra; i++) begin
      rand_pixel();
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 1'b0; bus.mode = 2'b00; bus.gain = 8'd0; bus.frame_start = 1'b0;
    bus.pixel_in = '0; bus.pass_in = '0;
    exp_pix[0] = '0; exp_pix[1] = '0; exp_pass[0] = '0; exp_pass[1] = '0;
    @(negedge clk);

    // Reset with a busy input stream: outputs stay zero.
    for (int i = 0; i < 3; i++) begin
      rand_pixel();
      bus.frame_start = 1'b1;
      tick();
    end
    bus.frame_start = 1'b0;
    check("reset_pixel", 32'(bus.pixel_out), 32'd0);
    rst = 1'b0;

    // Known pixel at unity gain.
    bus.pixel_in = {9'h1AB, 7'h55, 8'hC3};
    bus.pass_in  = 24'hA5F00F;
    tick(); tick();
    check("unity_pixel", 32'(bus.pixel_out), 32'({9'h1AB, 7'h55, 8'hC3}));
    for (int i = 0; i < 5; i++) begin rand_pixel(); tick(); end

    // en toggles without frame_start: no effect.
    bus.en = 1'b1;
    for (int i = 0; i < 3; i++) begin set_sat(100); tick(); end
    bus.en = 1'b0; set_sat(100); tick();
    bus.en = 1'b1; set_sat(100); tick();
    check("midframe_sat", 32'(bus.pixel_out[VAL_W +: SAT_W]), 32'd100);

    // Grayscale fade: 8 frames down to zero.
    for (int f = 0; f < 9; f++) frame(3);
    set_sat(127); tick(); tick();
    check("gray_sat", 32'(bus.pixel_out[VAL_W +: SAT_W]), 32'd0);
    check("gray_fading", 32'(bus.fading), 32'd0);

    // Gain mode at 255 with saturation clamp.
    bus.en = 1'b0; bus.mode = 2'b10; bus.gain = 8'd255;
    for (int f = 0; f < 17; f++) frame(2);
    set_sat(8'h7F); tick();
    set_sat(8'h20); tick();
    check("clamp_7f", 32'(bus.pixel_out[VAL_W +: SAT_W]), 32'h7F);
    rand_pixel(); tick();
    check("clamp_20", 32'(bus.pixel_out[VAL_W +: SAT_W]), 32'h3F);

    // Back to unity, then a target just below unity: one clamped step.
    bus.mode = 2'b00;
    for (int f = 0; f < 9; f++) frame(2);
    bus.mode = 2'b10; bus.gain = 8'd120;
    frame(1);
    check("g120_fading", 32'(bus.fading), 32'd0);
    set_sat(64); tick(); tick();
    check("g120_sat", 32'(bus.pixel_out[VAL_W +: SAT_W]), 32'd60);

    // Back to unity, fade toward gray and reset at G = 64.
    bus.mode = 2'b11;
    for (int f = 0; f < 3; f++) frame(2);
    bus.en = 1'b1;
    for (int f = 0; f < 4; f++) frame(2);
    check("down_fading", 32'(bus.fading), 32'd1);
    rst = 1'b1; rand_pixel(); tick();
    check("abort_pixel", 32'(bus.pixel_out), 32'd0);
    check("abort_fading", 32'(bus.fading), 32'd0);
    rst = 1'b0; bus.en = 1'b0;
    set_sat(8'h55); tick(); tick();
    check("abort_unity", 32'(bus.pixel_out[VAL_W +: SAT_W]), 32'h55);

    // Random soak with occasional frame boundaries and resets.
    for (int i = 0; i < 400; i++) begin
      rand_pixel();
      bus.frame_start = ($urandom_range(0, 5) == 0);
      bus.en   = ($urandom_range(0, 3) == 0);
      bus.mode = 2'($urandom);
      bus.gain = 8'($urandom);
      rst      = ($urandom_range(0, 96) == 0);
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
